mult_div_unit: RTL and testbench



---
 rtl/mult_div_pkg.sv | 18 +
 rtl/mult_div_if.sv | 29 ++
 rtl/md_div_core.sv | 69 ++++++
 rtl/mult_div_unit.sv | 151 +++++++++++++++
 tb/tb_mult_div_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared types and constants for the
// sequential signed multiply/divide unit.
package mult_div_pkg;

  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    DONE
  } mdState_e;

endpackage

// File: rtl/mult_div_if.sv
// mult_div_if: request/response bundle between the control
// unit (master) and the mult/div responder (slave).
//   md_start/md_op/a_in/b_in          : request
//   hi_out/lo_out/md_busy/md_done/div_zero : response
interface mult_div_if #(
  parameter int WIDTH = 32
);

  logic             md_start;
  logic             md_op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             md_busy;
  logic             md_done;
  logic             div_zero;

  modport master (
    output md_start, md_op, a_in, b_in,
    input  hi_out, lo_out, md_busy, md_done, div_zero
  );

  modport slave (
    input  md_start, md_op, a_in, b_in,
    output hi_out, lo_out, md_busy, md_done, div_zero
  );

endinterface

// File: rtl/md_div_core.sv
// md_div_core: restoring divider on operand magnitudes with
// MIPS sign fixup (quotient toward zero, remainder sign = dividend).
//   load      : capture signs and magnitudes of aIn/bIn
//   step      : one restoring iteration
//   quotient  : signed quotient, remainder: signed remainder
//   divisorZero : latched divisor is zero
//   earlyOut  : |a| < |b| (only with MD_EARLY_OUT_EN, valid before steps)
module md_div_core
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divisorZero,
  output logic             earlyOut
);

  logic             aSign;
  logic             qNeg;
  logic [WIDTH-1:0] quoMag;
  logic [WIDTH-1:0] remMag;
  logic [WIDTH-1:0] divMag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // remMag < divMag always holds, so the true difference
  // fits in WIDTH bits whenever the trial subtract succeeds.
  assign shifted = {remMag, quoMag[WIDTH-1]};
  assign trial   = shifted[WIDTH-1:0] - divMag;
  assign fits    = shifted >= {1'b0, divMag};

  always_ff @(posedge clk) begin
    if (reset) begin
      aSign  <= 1'b0;
      qNeg   <= 1'b0;
      quoMag <= '0;
      remMag <= '0;
      divMag <= '0;
    end else if (load) begin
      aSign  <= aIn[WIDTH-1];
      qNeg   <= aIn[WIDTH-1] ^ bIn[WIDTH-1];
      quoMag <= aIn[WIDTH-1] ? -aIn : aIn;
      remMag <= '0;
      divMag <= bIn[WIDTH-1] ? -bIn : bIn;
    end else if (step) begin
      quoMag <= {quoMag[WIDTH-2:0], fits};
      remMag <= fits ? trial : shifted[WIDTH-1:0];
    end
  end

  assign quotient    = qNeg ? -quoMag : quoMag;
  assign remainder   = aSign ? -remMag : remMag;
  assign divisorZero = divMag == '0;

`ifdef MD_EARLY_OUT_EN
  assign earlyOut = quoMag < divMag;
`else
  assign earlyOut = 1'b0;
`endif

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed MULT (radix-2 Booth) / DIV
// responder; 33-cycle latency, one-cycle md_done pulse.
//   clk, reset : clock, synchronous active-high reset
//   md (slave) : start/op/a/b request, hi/lo/busy/done/div_zero
//   MD_EARLY_OUT_EN : zero-operand MULT and |a|<|b| DIV finish at E1
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = MD_ITER
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave md
);

  mdState_e            state;
  mdState_e            nextState;
  logic [MD_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH:0]      acc;
  logic [WIDTH:0]      accAdd;
  logic [WIDTH-1:0]    mplier;
  logic                qm1;
  logic [WIDTH-1:0]    hiQ;
  logic [WIDTH-1:0]    loQ;
  logic                divZeroQ;
  logic                iterDone;
  logic                multEarly;
  logic                divEarly;
  logic                coreEarly;
  logic                divisorZero;
  logic [WIDTH-1:0]    quotient;
  logic [WIDTH-1:0]    remainder;
  logic                divLoad;
  logic                divStep;

  assign iterDone = cnt == MD_CNT_W'(ITER);
  assign divLoad  = (state == IDLE) && md.md_start
                    && (md.md_op == MD_OP_DIV);
  assign divStep  = (state == DIV) && (nextState == DIV);
  assign divEarly = (cnt == '0) && coreEarly;

`ifdef MD_EARLY_OUT_EN
  assign multEarly = (cnt == '0)
                     && ((mcand == '0) || (mplier == '0));
`else
  assign multEarly = 1'b0;
`endif

  md_div_core #(
    .WIDTH(WIDTH)
  ) uDiv (
    .clk        (clk),
    .reset      (reset),
    .load       (divLoad),
    .step       (divStep),
    .aIn        (md.a_in),
    .bIn        (md.b_in),
    .quotient   (quotient),
    .remainder  (remainder),
    .divisorZero(divisorZero),
    .earlyOut   (coreEarly)
  );

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (md.md_start)
        nextState = (md.md_op == MD_OP_DIV) ? DIV : MULT;
      MULT: if (iterDone || multEarly)
        nextState = DONE;
      DIV: if (iterDone || divisorZero || divEarly)
        nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Acc carries one guard bit so that subtracting the most
  // negative multiplicand cannot overflow.
  always_comb begin
    accAdd = acc;
    unique case ({mplier[0], qm1})
      2'b01:   accAdd = acc + {mcand[WIDTH-1], mcand};
      2'b10:   accAdd = acc - {mcand[WIDTH-1], mcand};
      default: accAdd = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      qm1      <= 1'b0;
      hiQ      <= '0;
      loQ      <= '0;
      divZeroQ <= 1'b0;
    end else begin
      state    <= nextState;
      divZeroQ <= 1'b0;
      unique case (state)
        IDLE: begin
          if (md.md_start) begin
            mcand  <= md.a_in;
            acc    <= '0;
            mplier <= md.b_in;
            qm1    <= 1'b0;
            cnt    <= '0;
          end
        end
        MULT: begin
          if (multEarly) begin
            hiQ <= '0;
            loQ <= '0;
          end else if (iterDone) begin
            hiQ <= acc[WIDTH-1:0];
            loQ <= mplier;
          end else begin
            {acc, mplier, qm1} <= {accAdd[WIDTH], accAdd, mplier};
            cnt <= cnt + MD_CNT_W'(1);
          end
        end
        DIV: begin
          if (divisorZero) begin
            divZeroQ <= 1'b1;
          end else if (divEarly) begin
            hiQ <= mcand;
            loQ <= '0;
          end else if (iterDone) begin
            hiQ <= remainder;
            loQ <= quotient;
          end else begin
            cnt <= cnt + MD_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign md.hi_out   = hiQ;
  assign md.lo_out   = loQ;
  assign md.md_busy  = (state == MULT) || (state == DIV);
  assign md.md_done  = state == DONE;
  assign md.div_zero = divZeroQ;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit.
// Expected values are hand-computed constants.
module tb_mult_div_unit;

`ifdef MD_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  int          lat;
  int          busyCnt;
  logic        busy0;
  logic        busyAtDone;
  logic        dzAtDone;
  logic [31:0] hiAtDone;
  logic [31:0] loAtDone;

  always #5 clk = ~clk;

  mult_div_if #(.WIDTH(32)) mdIf ();

  mult_div_unit #(
    .WIDTH(32),
    .ITER (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (mdIf)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Issue one request at E0 and wait (bounded) for md_done.
  // lat = index of the edge after which md_done is seen, -1 on timeout.
  task automatic runOp(input logic op, input logic [31:0] a,
                       input logic [31:0] b, input bit spam);
    int n;
    bit seen;
    @(negedge clk);
    mdIf.md_start = 1'b1;
    mdIf.md_op    = op;
    mdIf.a_in     = a;
    mdIf.b_in     = b;
    @(posedge clk);
    #1;
    mdIf.md_start = 1'b0;
    mdIf.md_op    = ~op;
    mdIf.a_in     = 32'hDEADBEEF;
    mdIf.b_in     = 32'h0;
    busy0   = mdIf.md_busy;
    n       = 0;
    busyCnt = 0;
    seen    = 0;
    while (!seen && n < 100) begin
      if (spam && (n % 5 == 2)) mdIf.md_start = 1'b1;
      @(posedge clk);
      n++;
      #1;
      mdIf.md_start = 1'b0;
      @(negedge clk);
      if (mdIf.md_done) seen = 1;
      else if (mdIf.md_busy) busyCnt++;
    end
    lat        = seen ? n : -1;
    busyAtDone = mdIf.md_busy;
    dzAtDone   = mdIf.div_zero;
    hiAtDone   = mdIf.hi_out;
    loAtDone   = mdIf.lo_out;
    if (spam) begin
      mdIf.md_start = 1'b1;
      @(posedge clk);
      #1;
      mdIf.md_start = 1'b0;
    end
  endtask

  task automatic chkOp(input string tag, input int expLat,
                       input logic [31:0] expHi,
                       input logic [31:0] expLo,
                       input logic expDz);
    chk({tag, "_lat"}, lat, expLat);
    chk({tag, "_hi"}, hiAtDone, expHi);
    chk({tag, "_lo"}, loAtDone, expLo);
    chk({tag, "_dz"}, {31'b0, dzAtDone}, {31'b0, expDz});
    chk({tag, "_busyDone"}, {31'b0, busyAtDone}, 32'd0);
  endtask

  initial begin
    int extra;
    reset         = 1'b1;
    mdIf.md_start = 1'b0;
    mdIf.md_op    = 1'b0;
    mdIf.a_in     = '0;
    mdIf.b_in     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_hi", mdIf.hi_out, 32'h0);
    chk("rst_lo", mdIf.lo_out, 32'h0);
    chk("rst_busy", {31'b0, mdIf.md_busy}, 32'd0);
    chk("rst_done", {31'b0, mdIf.md_done}, 32'd0);
    chk("rst_dz", {31'b0, mdIf.div_zero}, 32'd0);

    runOp(1'b0, 32'd7, 32'hFFFFFFFD, 0);
    chkOp("mul7xm3", 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    chk("mul7xm3_busy0", {31'b0, busy0}, 32'd1);
    chk("mul7xm3_busyCnt", busyCnt, 32);

    runOp(1'b0, 32'h80000000, 32'h80000000, 0);
    chkOp("mulMin", 33, 32'h40000000, 32'h00000000, 1'b0);

    runOp(1'b0, -32'sd12345, 32'd6789, 0);
    chkOp("mulMixed", 33, 32'hFFFFFFFF, 32'hFB012863, 1'b0);

    runOp(1'b1, 32'hFFFFFFF9, 32'd2, 0);
    chkOp("divM7by2", 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    chk("divM7by2_busyCnt", busyCnt, 32);

    runOp(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    chkOp("divOvf", 33, 32'h00000000, 32'h80000000, 1'b0);

    runOp(1'b1, 32'd100, -32'sd7, 0);
    chkOp("div100bym7", 33, 32'd2, 32'hFFFFFFF2, 1'b0);

    runOp(1'b1, -32'sd100, -32'sd7, 0);
    chkOp("divm100bym7", 33, 32'hFFFFFFFE, 32'd14, 1'b0);

    runOp(1'b0, 32'd3, 32'd5, 0);
    chkOp("mul3x5", 33, 32'd0, 32'd15, 1'b0);

    runOp(1'b1, 32'd5, 32'd0, 0);
    chkOp("divZero", 1, 32'd0, 32'd15, 1'b1);
    @(negedge clk);
    chk("divZero_dzPulse", {31'b0, mdIf.div_zero}, 32'd0);
    chk("divZero_donePulse", {31'b0, mdIf.md_done}, 32'd0);

    runOp(1'b1, 32'd3, 32'd10, 0);
    chkOp("divSmall", EARLY_LAT, 32'd3, 32'd0, 1'b0);

    runOp(1'b0, 32'd0, 32'd5, 0);
    chkOp("mulZero", EARLY_LAT, 32'd0, 32'd0, 1'b0);

    runOp(1'b0, 32'd3, 32'd5, 0);
    chkOp("mulPre", 33, 32'd0, 32'd15, 1'b0);

    // Reset applied on edge E10 of a running MULT.
    @(negedge clk);
    mdIf.md_start = 1'b1;
    mdIf.md_op    = 1'b0;
    mdIf.a_in     = 32'h12345678;
    mdIf.b_in     = 32'd9;
    @(posedge clk);
    #1;
    mdIf.md_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midRst_hi", mdIf.hi_out, 32'h0);
    chk("midRst_lo", mdIf.lo_out, 32'h0);
    chk("midRst_busy", {31'b0, mdIf.md_busy}, 32'd0);
    chk("midRst_done", {31'b0, mdIf.md_done}, 32'd0);

    runOp(1'b0, 32'd2, 32'd3, 0);
    chkOp("mulAfterRst", 33, 32'd0, 32'd6, 1'b0);

    runOp(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    chkOp("mulSpam", 33, 32'd0, 32'd1, 1'b0);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (mdIf.md_done || mdIf.md_busy) extra++;
    end
    chk("mulSpam_noExtra", extra, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
